rom_image_loader: RTL and testbench
===================================

Name: rom_image_loader

Overview:
- Writer side of the clocked ROM/RAM images used across the core.
- Takes the HPS ioctl byte download stream and filters it by ioctl_index.
- Packs bytes into data_width words and writes them through a single write port into the image memory, with back-pressure via ioctl_wait.
- Sits between hps_io and the boot/BASIC/kanji image memories, one instance per image.

Parameters:
- addr_width, 12, word address width of the target memory.
- data_width, 8, target word width; legal values 8 or 16.
- INDEX, 0, ioctl_index value this instance accepts.
- BASE_ADDR, 0, byte offset within the download that maps to word 0.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  image selector
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte address of ioctl_dout
- ioctl_dout  in  8  download byte
- ioctl_wait  out  1  stall request to hps_io
- mem_addr  out  addr_width  write word address
- mem_din  out  data_width  write data
- mem_we  out  1  write request, held until accepted
- mem_ack  in  1  target accepted write this cycle (tie 1 for plain BRAM)
- busy  out  1  load active or FIFO not drained
- done  out  1  image completely written
- overflow  out  1  sticky: byte fell outside the window

Behaviour:
- Reset values: ioctl_wait=0, mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, overflow=0. FSM goes to IDLE and the FIFO is emptied. A reset mid-load discards partial words and queued writes.
- sel = ioctl_download & (ioctl_index==INDEX). Bytes are accepted only when sel & ioctl_wr.
- off = ioctl_addr - BASE_ADDR. A byte with ioctl_addr < BASE_ADDR is ignored silently. A byte with off >= (2^addr_width)*(data_width/8) is dropped and sets overflow; overflow clears only on reset or at the next IDLE->LOAD.
- data_width=8: each accepted byte becomes a word at address off[addr_width-1:0].
- data_width=16: little-endian packing.
  - Even off: byte goes to the low-byte latch.
  - Odd off: word {byte, latch} is pushed at address off[addr_width:1].
  - An odd byte with no preceding even byte of the same word pushes with low byte 0x00.
  - A trailing even byte at end of download pushes with high byte 0x00.
- Write FIFO: 2 entries of {addr, data}.
  - mem_we = FIFO not empty. mem_addr/mem_din show the head entry.
  - The head pops on a cycle where mem_we & mem_ack.
  - A push and pop in the same cycle are both honoured; the count is unchanged.
- ioctl_wait is registered. It is 1 when the FIFO count is 2, or when the count is 1 and no pop occurs this cycle. This guarantees no byte is lost when ioctl_wr arrives one cycle after wait rises.
- A push while full is a design error. An assertion is kept in simulation only.
- FSM:
  - IDLE: busy=0. When sel rises, go to LOAD; clear done, overflow and the low-byte latch.
  - LOAD: busy=1. Accept bytes. When ioctl_download falls or the index changes, go to DRAIN. Push the pending trailing even byte the same cycle; if the FIFO is full, push it on the first free cycle.
  - DRAIN: busy=1. No new bytes. When the FIFO is empty and no trailing byte is pending, go to DONE.
  - DONE: done=1, busy=0. The next rising sel goes to LOAD and clears done.
- Latency: an accepted byte completing a word shows mem_we on the next cycle; with mem_ack=1 that word is written one cycle after that.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[15:0].
  - Reset/LOAD-entry value 0.
  - Each accepted in-window byte adds to a 16-bit sum, modulo 2^16.
  - The value is frozen from DONE until the next LOAD.
- Undefined: the port and adder are absent. All other behaviour is identical.

Test Plan:
- 8-bit, INDEX=0, mem_ack=1: bytes 0x11,0x22,0x33 at addr 0..2 -> three writes (0,0x11),(1,0x22),(2,0x33); done=1 two cycles after ioctl_download falls; overflow=0.
- 16-bit: bytes 0xAA,0xBB,0xCC at addr 0..2 -> writes (0,0xBBAA) then trailing (1,0x00CC) in DRAIN; done=1.
- Back-pressure: mem_ack=0 for 10 cycles, bytes every cycle -> ioctl_wait=1 after 2 queued words; no byte lost; release ack -> writes in order, ioctl_wait drops.
- Index filter and window: ioctl_index=1 with INDEX=0 -> no mem_we, done stays 0. INDEX=0, addr_width=4, data_width=8, byte at addr 16 -> dropped, overflow=1.
- Reset mid-load after 1 of 2 queued words -> all outputs 0 next cycle; a new download restarts cleanly.
- LOADER_CHECKSUM_EN: bytes 0xFF x 300 -> checksum=0x2AD4 at done.

Source files
------------

// File: rtl/rom_image_loader.sv
// rom_image_loader: filters the hps ioctl download by index and packs it into image memory writes.
// Define LOADER_CHECKSUM_EN to add a 16-bit running byte checksum output.
module rom_image_loader #(
  parameter int addr_width = 12,
  parameter int data_width = 8,
  parameter int INDEX      = 0,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  output logic                  ioctl_wait,
  output logic [addr_width-1:0] mem_addr,
  output logic [data_width-1:0] mem_din,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
`ifdef LOADER_CHECKSUM_EN
  , output logic [15:0]         checksum
`endif
);
  localparam int BPW = data_width / 8;
  localparam logic [25:0] LIMIT = 26'(BPW) << addr_width;
  localparam logic [24:0] BASE = 25'(BASE_ADDR);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic sel, sel_q, rise, enter;
  logic [24:0] off;
  logic acc, in_win, over;
  logic byte_req, pend, tdrain, tpush, want, push, pop, can_push;
  logic [addr_width-1:0] byte_addr, pend_addr, push_addr;
  logic [data_width-1:0] byte_data, pend_data, push_data;
  logic [1:0][addr_width-1:0] fa_q, fa_d;
  logic [1:0][data_width-1:0] fd_q, fd_d;
  logic rp_q, rp_d, wp_q, wp_d;
  logic [1:0] cnt_q, cnt_d;
  logic wait_q, wait_d, ovf_q, ovf_d;

  assign sel = ioctl_download & (ioctl_index == 8'(INDEX));
  assign rise = sel & ~sel_q;
  assign enter = (state_q == IDLE || state_q == DONE) & rise;
  assign off = ioctl_addr - BASE;
  assign over = {1'b0, off} >= LIMIT;
  assign acc = (state_q == LOAD) & sel & ioctl_wr & (ioctl_addr >= BASE);
  assign in_win = acc & ~over;
  assign pop = (cnt_q != 2'd0) & mem_ack;
  assign can_push = ~cnt_q[1] | pop;
  assign tdrain = pend & (state_q == DRAIN || (state_q == LOAD && !sel));
  assign tpush = tdrain & can_push;
  assign want = byte_req | tdrain;
  assign push = want & can_push;
  assign push_addr = byte_req ? byte_addr : pend_addr;
  assign push_data = byte_req ? byte_data : pend_data;

  generate
    if (data_width == 16) begin : g16
      // Even byte waits in the latch; it doubles as the pending trailing byte after LOAD.
      logic [7:0] lat_q, lat_d;
      logic [addr_width-1:0] la_q, la_d, word;
      logic lv_q, lv_d;
      assign word = off[addr_width:1];
      always_comb begin
        lat_d = lat_q;
        la_d = la_q;
        lv_d = lv_q;
        if (enter || tpush || (in_win && off[0])) lv_d = 1'b0;
        else if (in_win) begin
          lat_d = ioctl_dout;
          la_d = word;
          lv_d = 1'b1;
        end
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          lat_q <= '0;
          la_q <= '0;
          lv_q <= 1'b0;
        end else begin
          lat_q <= lat_d;
          la_q <= la_d;
          lv_q <= lv_d;
        end
      end
      assign byte_req = in_win & off[0];
      assign byte_addr = word;
      assign byte_data = {ioctl_dout, (lv_q && la_q == word) ? lat_q : 8'h00};
      assign pend = lv_q;
      assign pend_addr = la_q;
      assign pend_data = {8'h00, lat_q};
    end else begin : g8
      assign byte_req = in_win;
      assign byte_addr = off[addr_width-1:0];
      assign byte_data = ioctl_dout;
      assign pend = 1'b0;
      assign pend_addr = '0;
      assign pend_data = '0;
    end
  endgenerate

  always_comb begin
    fa_d = fa_q;
    fd_d = fd_q;
    if (push) begin
      fa_d[wp_q] = push_addr;
      fd_d[wp_q] = push_data;
    end
    wp_d = wp_q ^ push;
    rp_d = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    // Raised one entry early so a byte already in flight from hps_io still fits.
    wait_d = (cnt_q == 2'd2) | (cnt_q == 2'd1 & ~pop);
    ovf_d = enter ? 1'b0 : ovf_q | (acc & over);
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = rise ? LOAD : state_q;
      LOAD: state_d = sel ? LOAD : DRAIN;
      DRAIN: state_d = (cnt_q == 2'd0 && !pend) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= 1'b0;
      fa_q <= '0;
      fd_q <= '0;
      rp_q <= 1'b0;
      wp_q <= 1'b0;
      cnt_q <= 2'd0;
      wait_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel;
      fa_q <= fa_d;
      fd_q <= fd_d;
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
      ovf_q <= ovf_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_we = cnt_q != 2'd0;
  assign mem_addr = fa_q[rp_q];
  assign mem_din = fd_q[rp_q];
  assign busy = (state_q == LOAD) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign overflow = ovf_q;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cs_q, cs_d;
  assign cs_d = enter ? 16'h0 : in_win ? cs_q + 16'(ioctl_dout) : cs_q;
  always_ff @(posedge clk) begin
    if (reset) cs_q <= 16'h0;
    else cs_q <= cs_d;
  end
  assign checksum = cs_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (reset || !(want && !can_push)) else $error("rom_image_loader: push while write FIFO full");
  end
`endif
endmodule

// File: tb/tb_rom_image_loader.sv
// tb_rom_image_loader: directed checks of an 8-bit (INDEX 0, 16-word window) and a 16-bit (INDEX 1) loader on one ioctl bus.
module tb_rom_image_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dl = 1'b0;
  logic [7:0] idx = 8'd0;
  logic wr = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0] dout = '0;
  logic ack8 = 1'b1, ack16 = 1'b1;
  logic w8, we8, busy8, done8, ovf8;
  logic [3:0] ma8;
  logic [7:0] md8;
  logic w16, we16, busy16, done16, ovf16;
  logic [11:0] ma16;
  logic [15:0] md16;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cs8, cs16;
`endif
  logic [31:0] got8[$], got16[$];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  rom_image_loader #(.addr_width(4), .data_width(8), .INDEX(0), .BASE_ADDR(0)) u8 (
    .clk(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(w8), .mem_addr(ma8), .mem_din(md8),
    .mem_we(we8), .mem_ack(ack8), .busy(busy8), .done(done8), .overflow(ovf8)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs8)
`endif
  );

  rom_image_loader #(.addr_width(12), .data_width(16), .INDEX(1), .BASE_ADDR(0)) u16 (
    .clk(clk), .reset(rst), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(w16), .mem_addr(ma16), .mem_din(md16),
    .mem_we(we16), .mem_ack(ack16), .busy(busy16), .done(done16), .overflow(ovf16)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(cs16)
`endif
  );

  always @(posedge clk) begin
    if (we8 && ack8) got8.push_back({16'(ma8), 16'(md8)});
    if (we16 && ack16) got16.push_back({4'h0, ma16, md16});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] i);
    idx = i;
    dl = 1'b1;
    tick(1);
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while ((w8 || w16) && n < 100) begin
      tick(1);
      n++;
    end
    chk("wait_bound", 32'(n < 100), 32'd1);
    addr = a;
    dout = d;
    wr = 1'b1;
    tick(1);
    wr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit wide);
    int n = 0;
    while (!(wide ? done16 : done8) && n < 50) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(n < 50), 32'd1);
  endtask

  initial begin
    tick(2);
    chk("rst_we", we8, 0);
    chk("rst_addr", ma8, 0);
    chk("rst_din", md8, 0);
    chk("rst_wait", w8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_ovf", ovf8, 0);
    rst = 1'b0;
    tick(1);

    start(8'd0);
    chk("t1_busy", busy8, 1);
    send(25'd0, 8'h11);
    chk("t1_lat_we", we8, 1);
    chk("t1_lat_w", {16'(ma8), 16'(md8)}, 32'h0000_0011);
    send(25'd1, 8'h22);
    send(25'd2, 8'h33);
    dl = 1'b0;
    tick(1);
    chk("t1_done_early", done8, 0);
    tick(1);
    chk("t1_done", done8, 1);
    chk("t1_busy_end", busy8, 0);
    chk("t1_ovf", ovf8, 0);
    chk("t1_n", got8.size(), 3);
    chk("t1_w0", got8[0], 32'h0000_0011);
    chk("t1_w1", got8[1], 32'h0001_0022);
    chk("t1_w2", got8[2], 32'h0002_0033);
    chk("idx_n16", got16.size(), 0);
    chk("idx_done16", done16, 0);
    chk("idx_busy16", busy16, 0);

    got8.delete();
    start(8'd0);
    send(25'd16, 8'h55);
    chk("t2_ovf", ovf8, 1);
    send(25'd15, 8'h66);
    dl = 1'b0;
    wait_done("t2_done_to", 1'b0);
    chk("t2_ovf_sticky", ovf8, 1);
    chk("t2_n", got8.size(), 1);
    chk("t2_w0", got8[0], 32'h000F_0066);

    got8.delete();
    ack8 = 1'b0;
    start(8'd0);
    chk("t3_ovf_clr", ovf8, 0);
    send(25'd0, 8'hA0);
    send(25'd1, 8'hA1);
    tick(3);
    chk("t3_wait", w8, 1);
    chk("t3_we", we8, 1);
    chk("t3_head", {16'(ma8), 16'(md8)}, 32'h0000_00A0);
    chk("t3_none", got8.size(), 0);
    fork
      begin
        send(25'd2, 8'hA2);
        send(25'd3, 8'hA3);
      end
      begin
        tick(6);
        ack8 = 1'b1;
      end
    join
    tick(4);
    chk("t3_wait_drop", w8, 0);
    chk("t3_we_drop", we8, 0);
    dl = 1'b0;
    wait_done("t3_done_to", 1'b0);
    chk("t3_n", got8.size(), 4);
    chk("t3_w0", got8[0], 32'h0000_00A0);
    chk("t3_w1", got8[1], 32'h0001_00A1);
    chk("t3_w2", got8[2], 32'h0002_00A2);
    chk("t3_w3", got8[3], 32'h0003_00A3);

    got8.delete();
    ack8 = 1'b0;
    start(8'd0);
    send(25'd0, 8'h77);
    chk("t4_queued", we8, 1);
    rst = 1'b1;
    dl = 1'b0;
    tick(1);
    chk("t4_we", we8, 0);
    chk("t4_addr", ma8, 0);
    chk("t4_din", md8, 0);
    chk("t4_wait", w8, 0);
    chk("t4_busy", busy8, 0);
    chk("t4_done", done8, 0);
    chk("t4_ovf", ovf8, 0);
    rst = 1'b0;
    ack8 = 1'b1;
    tick(1);
    start(8'd0);
    send(25'd2, 8'h99);
    dl = 1'b0;
    wait_done("t4_done_to", 1'b0);
    chk("t4_n", got8.size(), 1);
    chk("t4_w0", got8[0], 32'h0002_0099);

    got8.delete();
    got16.delete();
    start(8'd1);
    send(25'd0, 8'hAA);
    send(25'd1, 8'hBB);
    send(25'd2, 8'hCC);
    dl = 1'b0;
    wait_done("t5_done_to", 1'b1);
    chk("t5_done", done16, 1);
    chk("t5_busy", busy16, 0);
    chk("t5_n", got16.size(), 2);
    chk("t5_w0", got16[0], 32'h0000_BBAA);
    chk("t5_w1", got16[1], 32'h0001_00CC);
    chk("t5_n8", got8.size(), 0);

    got16.delete();
    start(8'd1);
    chk("t6_done_clr", done16, 0);
    send(25'd5, 8'h12);
    dl = 1'b0;
    wait_done("t6_done_to", 1'b1);
    chk("t6_n", got16.size(), 1);
    chk("t6_w0", got16[0], 32'h0002_1200);

`ifdef LOADER_CHECKSUM_EN
    start(8'd1);
    chk("cs_clr", cs16, 0);
    for (int i = 0; i < 300; i++) send(25'(i), 8'hFF);
    dl = 1'b0;
    wait_done("cs_done_to", 1'b1);
    chk("cs_sum", cs16, 32'h2AD4);
    tick(3);
    chk("cs_frozen", cs16, 32'h2AD4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
